midi_in_receiver: RTL and testbench

//  MIDI IN receiver: the inbound counterpart of the midi_out transmitter. Serial 8N1 at
//  31250 baud, oversampled 16x from the system clock. Sits beside the UART/MIDI register

---
 rtl/midi_in_receiver.sv | 143 ++++++++++++++
 tb/tb_midi_in_receiver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/midi_in_receiver.sv
// MIDI IN receiver: 8N1 serial, 16x oversampled with a 7/8/9 majority vote, into a small FWFT FIFO.
// Latency: data_valid rises 1 clk after the stop-bit decision. A push into a full FIFO without a rd is dropped and sets overrun.
module midi_in_receiver #(
    parameter int CLKFREQ   = 28000000,
    parameter int BAUD      = 31250,
    parameter int FIFO_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       midi_in,
    input  logic       rd,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       fifo_full,
    output logic       overrun,
    output logic       framing_err,
    input  logic       clr_err,
    output logic       busy
);
    localparam int DIV   = CLKFREQ / (BAUD * 16);
    localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int CW    = FIFO_LOG2 + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t         state, state_nxt;
    logic           sync1, sync2, rx, rx_prev;
    logic [DW-1:0]  div_cnt;
    logic [3:0]     sub_cnt;
    logic [2:0]     bit_cnt;
    logic           s7, s8, maj;
    logic [7:0]     shreg, push_dat;
    logic           push_req;
    logic           tick, decide, wrap, start_edge, byte_done, frame_err;

    logic [7:0]           mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 do_rd, do_wr;

    assign rx         = sync2;
    assign tick       = (div_cnt == DW'(DIV - 1));
    assign decide     = tick && (sub_cnt == 4'd9);
    assign wrap       = tick && (sub_cnt == 4'd15);
    assign start_edge = (state == IDLE) && rx_prev && !rx;
    assign maj        = (s7 & s8) | (s7 & rx) | (s8 & rx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
            state   <= IDLE;
        end else begin
            sync1   <= midi_in;
            sync2   <= sync1;
            rx_prev <= rx;
            state   <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        byte_done = 1'b0;
        frame_err = 1'b0;
        case (state)
            IDLE:  if (start_edge) state_nxt = START;
            START: begin
                if (decide && maj) state_nxt = IDLE;
                else if (wrap)     state_nxt = DATA;
            end
            DATA:  if (wrap && bit_cnt == 3'd7) state_nxt = STOP;
            STOP: begin
                if (decide) begin
                    byte_done = maj;
                    frame_err = !maj;
                    state_nxt = maj ? IDLE : BRK;
                end
            end
            BRK:   if (rx) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bit timing restarts on the start edge so sub-count 8 lands mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            sub_cnt  <= '0;
            bit_cnt  <= '0;
            s7       <= 1'b1;
            s8       <= 1'b1;
            shreg    <= '0;
            push_req <= 1'b0;
            push_dat <= '0;
        end else begin
            if (start_edge || tick) div_cnt <= '0;
            else                    div_cnt <= div_cnt + 1'b1;
            if (start_edge)         sub_cnt <= '0;
            else if (tick)          sub_cnt <= sub_cnt + 1'b1;
            if (tick && sub_cnt == 4'd7) s7 <= rx;
            if (tick && sub_cnt == 4'd8) s8 <= rx;
            if (state == START)             bit_cnt <= '0;
            else if (state == DATA && wrap) bit_cnt <= bit_cnt + 1'b1;
            if (state == DATA && decide) shreg <= {maj, shreg[7:1]};
            push_req <= byte_done;
            if (byte_done) push_dat <= shreg;
        end
    end

    assign data_valid = (count != '0);
    assign fifo_full  = (count == CW'(DEPTH));
    assign do_rd      = rd && data_valid;
    assign do_wr      = push_req && (!fifo_full || do_rd);
    assign data       = data_valid ? mem[rd_ptr] : 8'h00;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overrun     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new event wins over a simultaneous clear.
            overrun     <= (push_req && fifo_full && !do_rd) || (overrun && !clr_err);
            framing_err <= frame_err || (framing_err && !clr_err);
        end
    end
endmodule

// File: tb/tb_midi_in_receiver.sv
// Bench for midi_in_receiver: serial frames driven at bit level, checked against a queue model of the FIFO and flags.
`timescale 1ns/1ps
module tb_midi_in_receiver;
    localparam int CLKFREQ   = 2000000;
    localparam int BAUD      = 31250;
    localparam int FIFO_LOG2 = 2;
    localparam int DEPTH     = 4;
    localparam int BIT       = 16 * (CLKFREQ / (BAUD * 16));

    logic       clk, rst_n, midi_in, rd, clr_err;
    logic [7:0] data;
    logic       data_valid, fifo_full, overrun, framing_err, busy;

    midi_in_receiver #(.CLKFREQ(CLKFREQ), .BAUD(BAUD), .FIFO_LOG2(FIFO_LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .midi_in(midi_in), .rd(rd),
        .data(data), .data_valid(data_valid), .fifo_full(fifo_full),
        .overrun(overrun), .framing_err(framing_err), .clr_err(clr_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int         checks, failures;
    logic [7:0] q[$];
    logic       exp_ovr, exp_fer;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        midi_in = 1'b0;
        hold(BIT);
        for (int i = 0; i < 8; i++) begin
            midi_in = b[i];
            hold(BIT);
        end
        midi_in = stop_val;
        hold(BIT);
    endtask

    task automatic model_push(input logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else exp_ovr = 1'b1;
    endtask

    task automatic check_state(input string tag);
        logic [7:0] head;
        head = (q.size() != 0) ? q[0] : 8'h00;
        chk({tag, "/valid"}, 32'(data_valid), 32'(q.size() != 0));
        chk({tag, "/full"},  32'(fifo_full),  32'(q.size() == DEPTH));
        chk({tag, "/data"},  32'(data),       32'(head));
        chk({tag, "/ovr"},   32'(overrun),    32'(exp_ovr));
        chk({tag, "/fer"},   32'(framing_err), 32'(exp_fer));
    endtask

    task automatic pop();
        rd = 1'b1;
        hold(1);
        rd = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic drain(input string tag);
        while (q.size() != 0) begin
            check_state(tag);
            pop();
        end
        check_state(tag);
    endtask

    task automatic clear_flags();
        clr_err = 1'b1;
        hold(1);
        clr_err = 1'b0;
        exp_ovr = 1'b0;
        exp_fer = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] t2 [3];
        logic [7:0] b;
        int         t;
        clk = 0; rst_n = 0; midi_in = 1; rd = 0; clr_err = 0;
        checks = 0; failures = 0; exp_ovr = 0; exp_fer = 0;
        t2 = '{8'h90, 8'h3C, 8'h7F};

        hold(3);
        chk("reset", 32'({data, data_valid, fifo_full, overrun, framing_err, busy}), 32'h0);
        rst_n = 1;
        hold(BIT);

        send_byte(8'h90, 1'b1);
        model_push(8'h90);
        check_state("t1");
        chk("t1_data", 32'(data), 32'h90);
        pop();
        chk("t1_empty", 32'(data_valid), 32'h0);

        foreach (t2[i]) begin
            send_byte(t2[i], 1'b1);
            model_push(t2[i]);
        end
        check_state("t2");
        drain("t2");

        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            hold($urandom_range(0, BIT));
            send_byte(b, 1'b1);
            model_push(b);
            check_state("rnd");
            repeat ($urandom_range(0, 2)) pop();
            check_state("rnd_pop");
            if (exp_ovr) begin
                clear_flags();
                check_state("rnd_clr");
            end
        end
        drain("rnd");

        for (int i = 0; i < 5; i++) begin
            send_byte(8'(8'h10 + i), 1'b1);
            model_push(8'(8'h10 + i));
        end
        check_state("t3");
        chk("t3_ovr", 32'(overrun), 32'h1);
        clear_flags();
        check_state("t3_clr");
        drain("t3");

        send_byte(8'h55, 1'b0);
        exp_fer = 1'b1;
        chk("t4_fer", 32'(framing_err), 32'h1);
        chk("t4_nopush", 32'(data_valid), 32'h0);
        hold(5 * BIT);
        clear_flags();
        hold(15 * BIT);
        midi_in = 1'b1;
        hold(BIT);
        check_state("t4_brk");
        send_byte(8'h42, 1'b1);
        model_push(8'h42);
        check_state("t4");
        drain("t4");

        midi_in = 1'b0;
        hold(2);
        midi_in = 1'b1;
        hold(6);
        chk("t5_busy_rise", 32'(busy), 32'h1);
        hold(BIT);
        chk("t5_busy_fall", 32'(busy), 32'h0);
        check_state("t5");

        for (int i = 0; i < 4; i++) begin
            send_byte(8'(8'hC0 + i), 1'b1);
            model_push(8'(8'hC0 + i));
        end
        check_state("t6_full");
        fork
            send_byte(8'h5E, 1'b1);
            begin
                t = 0;
                while (busy !== 1'b1 && t < 2 * BIT) begin @(negedge clk); t++; end
                chk("t6_busy_rise_timeout", 32'(t < 2 * BIT), 32'h1);
                t = 0;
                while (busy !== 1'b0 && t < 12 * BIT) begin @(negedge clk); t++; end
                chk("t6_busy_fall_timeout", 32'(t < 12 * BIT), 32'h1);
                rd = 1'b1;
                @(posedge clk);
                #1 rd = 1'b0;
            end
        join
        void'(q.pop_front());
        q.push_back(8'h5E);
        check_state("t6_rdpush");
        drain("t6");

        fork
            send_byte(8'h00, 1'b1);
            begin
                hold(4 * BIT + BIT / 2);
                rst_n = 1'b0;
                hold(2);
                chk("t6_rst", 32'({data, data_valid, fifo_full, overrun, framing_err, busy}), 32'h0);
            end
        join
        q.delete();
        exp_ovr = 1'b0;
        exp_fer = 1'b0;
        hold(BIT);
        rst_n = 1'b1;
        hold(BIT);
        send_byte(8'hA5, 1'b1);
        model_push(8'hA5);
        check_state("t6_a5");
        chk("t6_a5_data", 32'(data), 32'hA5);
        drain("t6_a5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
